instr_decode_stage: RTL and testbench
=====================================

Name: instr_decode_stage

Overview:
Registered RV32I decode stage that replaces the flat field-slicing decoder. It extracts register and function fields, classifies the instruction format, generates the sign-extended immediate at XLEN width and flags illegal encodings. It sits between fetch and the register-file/execute stage. A valid/ready handshake with a skid buffer gives full throughput under backpressure, and a flush input supports branch redirects.

Parameters:
XLEN, 32, datapath width of in_pc/out_pc/imm; legal values are 32 and 64.
SKID_EN, 1, 1 = two-entry skid buffer (in_ready is registered); 0 = single register with in_ready = !out_valid || out_ready.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
flush  input  1  discard all buffered instructions this cycle
in_valid  input  1  in_instr/in_pc valid
in_ready  output  1  stage can accept input
in_instr  input  32  raw instruction word
in_pc  input  XLEN  PC of in_instr
out_valid  output  1  decoded bundle valid
out_ready  input  1  downstream accepts bundle
out_pc  output  XLEN  PC of the decoded instruction
opcode  output  7  instr[6:0]
rd  output  5  instr[11:7], or 0 if unused by the format
rs1  output  5  instr[19:15], or 0 if unused
rs2  output  5  instr[24:20], or 0 if unused
funct3  output  3  instr[14:12]
funct7  output  7  instr[31:25]
fmt  output  3  0=R 1=I 2=S 3=B 4=U 5=J 7=NONE
imm  output  XLEN  sign-extended immediate
illegal  output  1  encoding not in RV32I base set

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, skid valid=0, all data outputs=0, in_ready=1 from the next cycle.
- Transfers: input accepted on in_valid && in_ready; output consumed on out_valid && out_ready.
- Latency: 1 cycle. An instruction accepted at edge N is presented at out_* after edge N.
- Decode is combinational on in_instr and is captured into the output register or the skid register. Outputs are fully registered.
- Opcode map:
  - 0110111 LUI, 0010111 AUIPC: U format.
  - 1101111 JAL: J format.
  - 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM, 0001111 MISC-MEM, 1110011 SYSTEM: I format.
  - 1100011 BRANCH: B format.
  - 0100011 STORE: S format.
  - 0110011 OP: R format.
- Illegal: instr[1:0]!=2'b11, or opcode not in the map. Then fmt=7, imm=0, rd=rs1=rs2=0 and illegal=1. The bundle still passes through the handshake; it is not dropped.
- Field zeroing by format:
  - R: all register fields kept.
  - I: rs2=0.
  - S, B: rd=0.
  - U, J: rs1=rs2=0.
  - funct3 and funct7 are always the raw bits.
- Immediates (sext = sign-extend from the top bit to XLEN):
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: sext({instr[31:12], 12'b0}).
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- Buffer states (SKID_EN=1): EMPTY, ONE (output register full), TWO (output and skid full).
  - in_ready = !skid_valid.
  - EMPTY: accept -> ONE.
  - ONE:
    - accept and consume -> ONE (output register reloads with the new entry).
    - accept without consume -> TWO (new entry goes to skid).
    - consume only -> EMPTY.
  - TWO: consume -> ONE (skid moves to the output register); no accept is possible.
- Ordering: instructions always emerge in acceptance order.
- Flush has priority over everything:
  - Both valids clear at the edge.
  - An input handshaking in the same cycle is dropped.
  - out_valid=0 the following cycle.
  - Data registers may retain stale values.
- rst overrides flush. Reset mid-stream discards all state identically to flush and also zeroes the data registers.
- Output stability: while out_valid && !out_ready, all out_* signals hold stable.

Test Plan:
- Reset, then in_instr=0xFFF00093 (addi x1,x0,-1), in_pc=0x100 -> next cycle: out_valid=1, fmt=1, rd=1, rs1=0, rs2=0, imm=0xFFFFFFFF, out_pc=0x100, illegal=0.
- 0x0020A423 (sw x2,8(x1)) -> fmt=2, rd=0, rs1=1, rs2=2, funct3=2, imm=0x8. Then 0xFE000EE3 (beq x0,x0,-4) -> fmt=3, imm=0xFFFFFFFC.
- XLEN=64, 0x800002B7 (lui x5,0x80000) -> fmt=4, rd=5, imm=0xFFFFFFFF80000000. Then in_instr=0x00000000 -> illegal=1, fmt=7, imm=0.
- Backpressure: stream 4 instrs with out_ready=0 -> 2 accepted, in_ready=0 from the cycle after the 2nd accept. Raise out_ready -> all 4 emerge in order, no gaps, no duplicates.
- Flush in state TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed entries and the same-cycle input never appear.
- Random valid/ready/flush for 10k cycles against a reference model -> every accepted, non-flushed instruction emerges exactly once, in order, with a matching decode.

Source files
------------

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - registered RV32I decode stage with valid/ready skid buffer and flush
// Decode is combinational on in_instr; the bundle is captured into the output or skid register.
module instr_decode_stage #(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  entry_t      dec, out_q, out_d, skid_q, skid_d;
  logic        out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [31:0] imm32;
  logic        accept;

  // An opcode outside the map also covers instr[1:0] != 2'b11, since those bits are part of it.
  always_comb begin
    dec        = '0;
    imm32      = '0;
    dec.pc     = in_pc;
    dec.opcode = in_instr[6:0];
    dec.funct3 = in_instr[14:12];
    dec.funct7 = in_instr[31:25];
    dec.rd     = in_instr[11:7];
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    case (in_instr[6:0])
      OPC_LUI, OPC_AUIPC: begin
        dec.fmt = FMT_U;
        imm32   = {in_instr[31:12], 12'b0};
        dec.rs1 = '0;
        dec.rs2 = '0;
      end
      OPC_JAL: begin
        dec.fmt = FMT_J;
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
        dec.rs1 = '0;
        dec.rs2 = '0;
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_MISC, OPC_SYSTEM: begin
        dec.fmt = FMT_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        dec.rs2 = '0;
      end
      OPC_BRANCH: begin
        dec.fmt = FMT_B;
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
        dec.rd  = '0;
      end
      OPC_STORE: begin
        dec.fmt = FMT_S;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec.rd  = '0;
      end
      OPC_OP: dec.fmt = FMT_R;
      default: begin
        dec.fmt     = FMT_NONE;
        dec.illegal = 1'b1;
        dec.rd      = '0;
        dec.rs1     = '0;
        dec.rs2     = '0;
      end
    endcase
    dec.imm = XLEN'($signed(imm32));
  end

  assign in_ready = SKID_EN ? !skid_valid_q : (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Output register frees up when empty or consumed; the skid entry always drains first.
  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_d        = out_q;
    skid_d       = skid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_q.pc;
  assign opcode    = out_q.opcode;
  assign rd        = out_q.rd;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign funct3    = out_q.funct3;
  assign funct7    = out_q.funct7;
  assign fmt       = out_q.fmt;
  assign imm       = out_q.imm;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - directed and scoreboarded checks of instr_decode_stage
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [63:0] in_pc64;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, illegal;
  logic [31:0] out_pc, imm;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3, fmt;

  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] out_pc64, imm64;
  logic [6:0]  opcode64, funct7_64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  funct3_64, fmt64;

  int n_cmp = 0;
  int n_err = 0;

  assign in_pc64 = {32'b0, in_pc};

  always #5 clk = ~clk;

  instr_decode_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .fmt(fmt), .imm(imm), .illegal(illegal)
  );

  instr_decode_stage #(.XLEN(64), .SKID_EN(1'b1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(in_pc64), .out_valid(out_valid64), .out_ready(out_ready),
    .out_pc(out_pc64), .opcode(opcode64), .rd(rd64), .rs1(rs1_64), .rs2(rs2_64),
    .funct3(funct3_64), .funct7(funct7_64), .fmt(fmt64), .imm(imm64), .illegal(illegal64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Independent reference decode: 32-bit immediate, 64-bit result is its sign extension.
  function automatic void model(input logic [31:0] i, output logic [2:0] f,
                                output logic [4:0] erd, output logic [4:0] ers1,
                                output logic [4:0] ers2, output logic [31:0] im,
                                output logic il);
    logic [31:0] ii, is, ib, iu, ij;
    ii = {{20{i[31]}}, i[31:20]};
    is = {{20{i[31]}}, i[31:25], i[11:7]};
    ib = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    iu = {i[31:12], 12'b0};
    ij = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    case (i[6:0])
      7'h37, 7'h17:                      f = 3'd4;
      7'h6F:                             f = 3'd5;
      7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: f = 3'd1;
      7'h63:                             f = 3'd3;
      7'h23:                             f = 3'd2;
      7'h33:                             f = 3'd0;
      default:                           f = 3'd7;
    endcase
    il   = (f == 3'd7);
    erd  = (f == 3'd0 || f == 3'd1 || f == 3'd4 || f == 3'd5) ? i[11:7] : 5'd0;
    ers1 = (f <= 3'd3) ? i[19:15] : 5'd0;
    ers2 = (f == 3'd0 || f == 3'd2 || f == 3'd3) ? i[24:20] : 5'd0;
    case (f)
      3'd1:    im = ii;
      3'd2:    im = is;
      3'd3:    im = ib;
      3'd4:    im = iu;
      3'd5:    im = ij;
      default: im = 32'd0;
    endcase
  endfunction

  task automatic check_bundle(input logic [31:0] i, input logic [31:0] pc);
    logic [2:0]  f;
    logic [4:0]  erd, ers1, ers2;
    logic [31:0] im;
    logic        il;
    model(i, f, erd, ers1, ers2, im, il);
    check("rnd_pc", out_pc, pc);
    check("rnd_opcode", opcode, i[6:0]);
    check("rnd_funct3", funct3, i[14:12]);
    check("rnd_funct7", funct7, i[31:25]);
    check("rnd_fmt", fmt, f);
    check("rnd_rd", rd, erd);
    check("rnd_rs1", rs1, ers1);
    check("rnd_rs2", rs2, ers2);
    check("rnd_imm", imm, im);
    check("rnd_illegal", illegal, il);
    check("rnd_pc64", out_pc64, {32'b0, pc});
    check("rnd_imm64", imm64, {{32{im[31]}}, im});
    check("rnd_fmt64", fmt64, f);
  endtask

  task automatic send1(input logic [31:0] i, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = i;
    in_pc    = pc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  logic [31:0] bp_i  [4] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0000006F};
  logic [31:0] bp_pc [4] = '{32'h400, 32'h404, 32'h408, 32'h40C};
  logic [31:0] q_i[$];
  logic [31:0] q_pc[$];

  initial begin
    int acc_cnt, nout, gaps, bound;
    logic acc_now, prev_hold;
    logic [31:0] snap_pc, snap_imm, pc_ctr;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_imm", imm, 32'h0);
    check("rst_fmt", fmt, 3'd0);

    out_ready = 1'b1;
    send1(32'hFFF00093, 32'h100);
    check("addi_valid", out_valid, 1'b1);
    check("addi_fmt", fmt, 3'd1);
    check("addi_rd", rd, 5'd1);
    check("addi_rs1", rs1, 5'd0);
    check("addi_rs2", rs2, 5'd0);
    check("addi_imm", imm, 32'hFFFFFFFF);
    check("addi_pc", out_pc, 32'h100);
    check("addi_illegal", illegal, 1'b0);

    send1(32'h0020A423, 32'h104);
    check("sw_fmt", fmt, 3'd2);
    check("sw_rd", rd, 5'd0);
    check("sw_rs1", rs1, 5'd1);
    check("sw_rs2", rs2, 5'd2);
    check("sw_funct3", funct3, 3'd2);
    check("sw_imm", imm, 32'h8);

    send1(32'hFE000EE3, 32'h108);
    check("beq_fmt", fmt, 3'd3);
    check("beq_imm", imm, 32'hFFFFFFFC);
    check("beq_rd", rd, 5'd0);

    send1(32'h800002B7, 32'h200);
    check("lui64_fmt", fmt64, 3'd4);
    check("lui64_rd", rd64, 5'd5);
    check("lui64_imm", imm64, 64'hFFFFFFFF80000000);
    check("lui32_imm", imm, 32'h80000000);
    check("lui64_rs1", rs1_64, 5'd0);

    send1(32'h00000000, 32'h204);
    check("zero_illegal", illegal64, 1'b1);
    check("zero_fmt", fmt64, 3'd7);
    check("zero_imm", imm64, 64'h0);
    check("zero_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;
    check("drained", out_valid, 1'b0);

    // Backpressure: only two entries fit while the sink stalls.
    out_ready = 1'b0;
    acc_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_instr = bp_i[acc_cnt];
      in_pc    = bp_pc[acc_cnt];
      @(negedge clk);
      acc_now = in_ready;
      @(posedge clk);
      #1;
      if (acc_now) acc_cnt++;
      if (acc_cnt == 2 && c == 1) check("bp_ready_low", in_ready, 1'b0);
    end
    check("bp_accepted", acc_cnt, 2);
    check("bp_hold_pc", out_pc, bp_pc[0]);
    out_ready = 1'b1;
    nout = 0;
    gaps = 0;
    for (int c = 0; c < 12 && nout < 4; c++) begin
      in_valid = (acc_cnt < 4);
      if (acc_cnt < 4) begin
        in_instr = bp_i[acc_cnt];
        in_pc    = bp_pc[acc_cnt];
      end
      @(negedge clk);
      acc_now = in_valid && in_ready;
      if (out_valid) begin
        check("bp_order", out_pc, bp_pc[nout]);
        nout++;
      end else begin
        gaps++;
      end
      @(posedge clk);
      #1;
      if (acc_now) acc_cnt++;
    end
    in_valid = 1'b0;
    check("bp_emerged", nout, 4);
    check("bp_gaps", gaps, 0);
    check("bp_no_dup", out_valid, 1'b0);

    // Flush while both registers are full, with a same-cycle input.
    out_ready = 1'b0;
    bound = 0;
    while (in_ready && bound < 8) begin
      in_valid = 1'b1;
      in_instr = 32'h00100093;
      in_pc    = 32'h500 + 32'(bound * 4);
      @(posedge clk);
      #1;
      bound++;
    end
    check("fl_filled", in_ready, 1'b0);
    in_instr = 32'h00200093;
    in_pc    = 32'h5F0;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", out_valid, 1'b0);
    check("fl_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("fl_gone", out_valid, 1'b0);
    end

    // Random traffic against a scoreboard.
    prev_hold = 1'b0;
    snap_pc   = '0;
    snap_imm  = '0;
    pc_ctr    = 32'h1000;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #1;
      flush     = ($urandom_range(0, 49) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = flush ? 1'b0 : ($urandom_range(0, 2) != 0);
      in_instr  = $urandom;
      if ($urandom_range(0, 7) != 0) begin
        case ($urandom_range(0, 10))
          0: in_instr[6:0] = 7'h37;
          1: in_instr[6:0] = 7'h17;
          2: in_instr[6:0] = 7'h6F;
          3: in_instr[6:0] = 7'h67;
          4: in_instr[6:0] = 7'h03;
          5: in_instr[6:0] = 7'h13;
          6: in_instr[6:0] = 7'h0F;
          7: in_instr[6:0] = 7'h73;
          8: in_instr[6:0] = 7'h63;
          9: in_instr[6:0] = 7'h23;
          default: in_instr[6:0] = 7'h33;
        endcase
      end
      in_pc  = pc_ctr;
      pc_ctr = pc_ctr + 32'd4;
      @(negedge clk);
      if (prev_hold) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_pc", out_pc, snap_pc);
        check("hold_imm", imm, snap_imm);
      end
      prev_hold = out_valid && !out_ready && !flush;
      snap_pc   = out_pc;
      snap_imm  = imm;
      if (out_valid && out_ready) begin
        if (q_i.size() == 0) begin
          check("sb_unexpected_out", out_pc, 32'hFFFFFFFF);
        end else begin
          check_bundle(q_i.pop_front(), q_pc.pop_front());
        end
      end
      if (flush) begin
        q_i.delete();
        q_pc.delete();
      end else if (in_valid && in_ready) begin
        q_i.push_back(in_instr);
        q_pc.push_back(in_pc);
      end
    end

    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    bound = 0;
    while (q_i.size() != 0 && bound < 10) begin
      @(negedge clk);
      if (out_valid) check_bundle(q_i.pop_front(), q_pc.pop_front());
      bound++;
    end
    check("sb_drained", q_i.size(), 0);
    @(negedge clk);
    check("sb_idle", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
